// File: rtl/alu_output_stage.sv
// alu_output_stage: classifies tagged ALU results and returns them to the
// originating requester port through a two-register pipeline. Per-port
// outstanding counters drive busy/stall indications, and any unbalanced
// issue/response traffic latches a sticky protocol error.
module alu_output_stage #(
  parameter int MAX_OUT = 3
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [0:1]  alu_req_id,
  input  logic [0:3]  alu_cmd,
  input  logic [0:63] alu_result,
  input  logic        issue_valid,
  input  logic [0:1]  issue_req_id,
  output logic [0:1]  out_resp1,
  output logic [0:1]  out_resp2,
  output logic [0:1]  out_resp3,
  output logic [0:1]  out_resp4,
  output logic [0:31] out_data1,
  output logic [0:31] out_data2,
  output logic [0:31] out_data3,
  output logic [0:31] out_data4,
  output logic [0:3]  port_busy,
  output logic [0:3]  issue_stall,
  output logic        proto_err
);

  localparam logic [1:0] MAX_CNT   = 2'(MAX_OUT);
  localparam logic [1:0] RESP_NONE = 2'b00;
  localparam logic [1:0] RESP_OK   = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b10;

  // Classified view of the incoming result
  logic [1:0]  cls_resp;
  logic [31:0] cls_data;

  // Stage A: classified result waiting to be steered
  logic        a_valid_reg;
  logic [1:0]  a_id_reg;
  logic [1:0]  a_resp_reg;
  logic [31:0] a_data_reg;

  // Stage B: response currently driven onto one port
  logic        b_valid_reg;
  logic [1:0]  b_id_reg;
  logic [1:0]  b_resp_reg;
  logic [31:0] b_data_reg;

  logic        proto_err_reg;
  logic [0:3]  err_set;

  logic [1:0]  resp_arr [4];
  logic [31:0] data_arr [4];

  // Decode command and carry/borrow extension into a response code
  always_comb begin
    cls_resp = RESP_ERR;
    cls_data = 32'h0;
    case (alu_cmd)
      4'd1, 4'd2: begin
        // Nonzero extension means the add carried out or the sub borrowed
        if (alu_result[0:31] == 32'h0) begin
          cls_resp = RESP_OK;
          cls_data = alu_result[32:63];
        end
      end
      4'd5, 4'd6: begin
        cls_resp = RESP_OK;
        cls_data = alu_result[32:63];
      end
      default: begin
        cls_resp = RESP_ERR;
        cls_data = 32'h0;
      end
    endcase
  end

  // Stage A capture; reset drops any in-flight result
  always_ff @(posedge c_clk) begin
    if (reset) begin
      a_valid_reg <= 1'b0;
      a_id_reg    <= 2'b00;
      a_resp_reg  <= RESP_NONE;
      a_data_reg  <= 32'h0;
    end else begin
      a_valid_reg <= alu_valid;
      a_id_reg    <= alu_req_id;
      a_resp_reg  <= cls_resp;
      a_data_reg  <= cls_data;
    end
  end

  // Stage B capture; holds each response for exactly one cycle
  always_ff @(posedge c_clk) begin
    if (reset) begin
      b_valid_reg <= 1'b0;
      b_id_reg    <= 2'b00;
      b_resp_reg  <= RESP_NONE;
      b_data_reg  <= 32'h0;
    end else begin
      b_valid_reg <= a_valid_reg;
      b_id_reg    <= a_id_reg;
      b_resp_reg  <= a_resp_reg;
      b_data_reg  <= a_data_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_port
      logic [1:0] cnt_reg;
      logic       inc;
      logic       dec;

      assign inc = issue_valid && (issue_req_id == 2'(gi));
      // Decrement coincides with stage B loading a response for this port
      assign dec = a_valid_reg && (a_id_reg == 2'(gi));

      assign err_set[gi] = (inc && (cnt_reg == MAX_CNT)) ||
                           (dec && (cnt_reg == 2'd0));

      // Outstanding-request counter, saturating at both ends
      always_ff @(posedge c_clk) begin
        if (reset) begin
          cnt_reg <= 2'd0;
        end else if (inc && !dec) begin
          if (cnt_reg != MAX_CNT) begin
            cnt_reg <= cnt_reg + 2'd1;
          end
        end else if (dec && !inc) begin
          if (cnt_reg != 2'd0) begin
            cnt_reg <= cnt_reg - 2'd1;
          end
        end
      end

      assign port_busy[gi]   = (cnt_reg != 2'd0);
      assign issue_stall[gi] = (cnt_reg == MAX_CNT);

      // Only the port addressed by stage B sees a nonzero response
      assign resp_arr[gi] = (b_valid_reg && (b_id_reg == 2'(gi))) ? b_resp_reg : RESP_NONE;
      assign data_arr[gi] = (b_valid_reg && (b_id_reg == 2'(gi))) ? b_data_reg : 32'h0;
    end
  endgenerate

  // Sticky protocol error, cleared only by reset
  always_ff @(posedge c_clk) begin
    if (reset) begin
      proto_err_reg <= 1'b0;
    end else if (|err_set) begin
      proto_err_reg <= 1'b1;
    end
  end

  assign proto_err = proto_err_reg;

  assign out_resp1 = resp_arr[0];
  assign out_resp2 = resp_arr[1];
  assign out_resp3 = resp_arr[2];
  assign out_resp4 = resp_arr[3];
  assign out_data1 = data_arr[0];
  assign out_data2 = data_arr[1];
  assign out_data3 = data_arr[2];
  assign out_data4 = data_arr[3];

endmodule

// File: tb/tb_alu_output_stage.sv
// tb_alu_output_stage: directed vectors with a scoreboard; the stimulus
// process queues expected responses, a monitor pops them as ports respond.
module tb_alu_output_stage;

  logic        c_clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [0:1]  alu_req_id;
  logic [0:3]  alu_cmd;
  logic [0:63] alu_result;
  logic        issue_valid;
  logic [0:1]  issue_req_id;
  logic [0:1]  out_resp1, out_resp2, out_resp3, out_resp4;
  logic [0:31] out_data1, out_data2, out_data3, out_data4;
  logic [0:3]  port_busy;
  logic [0:3]  issue_stall;
  logic        proto_err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    int          port;
    logic [1:0]  resp;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];

  alu_output_stage #(.MAX_OUT(3)) dut (
    .c_clk(c_clk), .reset(reset),
    .alu_valid(alu_valid), .alu_req_id(alu_req_id), .alu_cmd(alu_cmd),
    .alu_result(alu_result),
    .issue_valid(issue_valid), .issue_req_id(issue_req_id),
    .out_resp1(out_resp1), .out_resp2(out_resp2),
    .out_resp3(out_resp3), .out_resp4(out_resp4),
    .out_data1(out_data1), .out_data2(out_data2),
    .out_data3(out_data3), .out_data4(out_data4),
    .port_busy(port_busy), .issue_stall(issue_stall), .proto_err(proto_err)
  );

  always #5 c_clk = ~c_clk;

  // Cycle count used to check response latency
  always @(posedge c_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus; an expected response is queued when exp_port >= 0
  task automatic step(input bit iv, input logic [1:0] iid,
                      input bit av, input logic [1:0] aid,
                      input logic [3:0] cmd, input logic [63:0] res,
                      input int exp_port, input logic [1:0] exp_resp,
                      input logic [31:0] exp_data);
    exp_t e;
    issue_valid  = iv;
    issue_req_id = iid;
    alu_valid    = av;
    alu_req_id   = aid;
    alu_cmd      = cmd;
    alu_result   = res;
    if (av && exp_port >= 0) begin
      e.port = exp_port;
      e.resp = exp_resp;
      e.data = exp_data;
      e.due  = cyc + 2;
      sb.push_back(e);
    end
    @(negedge c_clk);
    issue_valid = 1'b0;
    alu_valid   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 2'd0, 0, 2'd0, 4'd0, 64'h0, -1, 2'b00, 32'h0);
  endtask

  // Monitor: any nonzero response is matched against the queue head
  always @(negedge c_clk) begin
    logic [1:0]  r [4];
    logic [31:0] d [4];
    exp_t e;
    r[0] = out_resp1; r[1] = out_resp2; r[2] = out_resp3; r[3] = out_resp4;
    d[0] = out_data1; d[1] = out_data2; d[2] = out_data3; d[3] = out_data4;
    if ((r[0] | r[1] | r[2] | r[3]) != 2'b00) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_resp: got %0h/%0h/%0h/%0h expected none (cycle %0d)",
                 r[0], r[1], r[2], r[3], cyc);
      end else begin
        e = sb.pop_front();
        chk("latency", 64'(cyc), 64'(e.due));
        for (int k = 0; k < 4; k++) begin
          chk($sformatf("port%0d_resp", k + 1), 64'(r[k]),
              (k == e.port) ? 64'(e.resp) : 64'h0);
          chk($sformatf("port%0d_data", k + 1), 64'(d[k]),
              (k == e.port) ? 64'(e.data) : 64'h0);
        end
        $display("resp port%0d resp=%0b data=%08h cycle %0d", e.port + 1,
                 r[e.port], d[e.port], cyc);
      end
    end else begin
      chk("idle_data", {d[0] | d[1], d[2] | d[3]}, 64'h0);
    end
  end

  // Watchdog: the directed run is short, so a long run means a hang
  initial begin
    repeat (5000) @(posedge c_clk);
    miscompares++;
    $display("FAIL watchdog: got cycle %0d expected completion", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    reset = 1'b1;
    issue_valid = 0; issue_req_id = 0;
    alu_valid = 0; alu_req_id = 0; alu_cmd = 0; alu_result = 0;
    repeat (3) @(negedge c_clk);
    chk("rst_busy", 64'(port_busy), 64'h0);
    chk("rst_stall", 64'(issue_stall), 64'h0);
    chk("rst_err", 64'(proto_err), 64'h0);
    reset = 1'b0;
    @(negedge c_clk);
    chk("post_rst_busy", 64'(port_busy), 64'h0);
    chk("post_rst_err", 64'(proto_err), 64'h0);

    // Add with no carry to port 3
    step(1, 2'd2, 0, 2'd0, 4'd0, 64'h0, -1, 2'b00, 32'h0);
    chk("p3_busy_set", 64'(port_busy[2]), 64'h1);
    step(0, 2'd0, 1, 2'd2, 4'd1, 64'h0000_0000_0000_0003, 2, 2'b01, 32'h3);
    idle(1);
    chk("p3_busy_clr", 64'(port_busy[2]), 64'h0);
    chk("p3_err", 64'(proto_err), 64'h0);
    $display("txn add port3 done");

    // Overflow, shift with same upper bits, invalid command, sub underflow
    step(1, 2'd0, 1, 2'd0, 4'd1, 64'h0000_0001_0000_0000, 0, 2'b10, 32'h0);
    step(1, 2'd0, 1, 2'd0, 4'd5, 64'h0000_0001_0000_0000, 0, 2'b01, 32'h0);
    step(1, 2'd1, 1, 2'd1, 4'd3, 64'h0000_0000_0000_1234, 1, 2'b10, 32'h0);
    step(1, 2'd1, 1, 2'd1, 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1, 2'b10, 32'h0);
    idle(2);
    $display("txn class checks done");

    // Back-to-back results to ports 1, 4, 1
    step(1, 2'd0, 1, 2'd0, 4'd1, 64'h0000_0000_0000_0005, 0, 2'b01, 32'h5);
    step(1, 2'd3, 1, 2'd3, 4'd6, 64'h0000_0000_DEAD_BEEF, 3, 2'b01, 32'hDEAD_BEEF);
    step(1, 2'd0, 1, 2'd0, 4'd2, 64'h0000_0000_0000_0007, 0, 2'b01, 32'h7);
    idle(3);
    chk("b2b_busy", 64'(port_busy), 64'h0);
    chk("b2b_err", 64'(proto_err), 64'h0);
    $display("txn back-to-back done");

    // Fill port 2 to the limit, then overissue
    step(1, 2'd1, 0, 2'd0, 4'd0, 64'h0, -1, 2'b00, 32'h0);
    step(1, 2'd1, 0, 2'd0, 4'd0, 64'h0, -1, 2'b00, 32'h0);
    chk("p2_stall_2", 64'(issue_stall[1]), 64'h0);
    step(1, 2'd1, 0, 2'd0, 4'd0, 64'h0, -1, 2'b00, 32'h0);
    chk("p2_stall_3", 64'(issue_stall[1]), 64'h1);
    chk("p2_err_ok", 64'(proto_err), 64'h0);
    step(1, 2'd1, 0, 2'd0, 4'd0, 64'h0, -1, 2'b00, 32'h0);
    chk("p2_overissue_err", 64'(proto_err), 64'h1);
    chk("p2_sat_stall", 64'(issue_stall[1]), 64'h1);
    step(0, 2'd0, 1, 2'd1, 4'd1, 64'h0000_0000_0000_0009, 1, 2'b01, 32'h9);
    idle(2);
    chk("p2_after_dec_stall", 64'(issue_stall[1]), 64'h0);
    chk("p2_after_dec_busy", 64'(port_busy[1]), 64'h1);
    chk("p2_err_sticky", 64'(proto_err), 64'h1);
    $display("txn saturation done");

    // Reset while a result sits in stage A: it must never emerge
    step(1, 2'd0, 1, 2'd0, 4'd1, 64'h0000_0000_0000_0001, -1, 2'b00, 32'h0);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
    chk("midrst_busy", 64'(port_busy), 64'h0);
    chk("midrst_stall", 64'(issue_stall), 64'h0);
    chk("midrst_err", 64'(proto_err), 64'h0);
    idle(3);
    $display("txn mid-reset done");

    // Response to idle port 4 flags an error but is delivered
    step(0, 2'd0, 1, 2'd3, 4'd5, 64'h0000_0000_0000_0042, 3, 2'b01, 32'h42);
    idle(2);
    chk("p4_idle_err", 64'(proto_err), 64'h1);
    chk("p4_idle_busy", 64'(port_busy[3]), 64'h0);
    $display("txn idle-port response done");

    idle(2);
    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
